// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, FSM encoding and GF(2^8) helpers.
// Provides NUM_ROUNDS, aesFsm_t, sbox(), xtime() and mix_column().
package aes_pkg;

   localparam int NUM_ROUNDS = 10;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } aesFsm_t;

   // FIPS-197 S-box, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Byte b lives at bit (255-b)*8+7 downward, i.e. {~b, 3'b111}.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[{~b, 3'b111} -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column bytes a0..a3 with a0 in [31:24].
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES round (SubBytes, ShiftRows,
// MixColumns unless lastRound, AddRoundKey). state/roundKey in, nextState out.
module aes_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] roundKey,
   input  logic         lastRound,
   output logic [127:0] nextState
);

   logic [127:0] subShifted;
   logic [127:0] mixed;

   // Byte index is 4*column + row; row r rotates left by r columns.
   always_comb begin
      subShifted = '0;
      mixed      = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            subShifted[127 - 8*(4*c + r) -: 8] =
               sbox(state[127 - 8*(4*((c + r) % 4) + r) -: 8]);
         end
         mixed[127 - 32*c -: 32] = mix_column(subShifted[127 - 32*c -: 32]);
      end
   end

   assign nextState = (lastRound ? subShifted : mixed) ^ roundKey;

endmodule

// File: rtl/aes_encrypt_core.sv
// aes_encrypt_core: iterative AES-128 encryption, one round per clock.
// Ports: clock, reset (sync, high), startEncryption, keysReady,
//   plainText, roundKey0..10 in; cipherText, busy, done out.
module aes_encrypt_core #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         startEncryption,
   input  logic         keysReady,
   input  logic [127:0] plainText,
   input  logic [127:0] roundKey0,
   input  logic [127:0] roundKey1,
   input  logic [127:0] roundKey2,
   input  logic [127:0] roundKey3,
   input  logic [127:0] roundKey4,
   input  logic [127:0] roundKey5,
   input  logic [127:0] roundKey6,
   input  logic [127:0] roundKey7,
   input  logic [127:0] roundKey8,
   input  logic [127:0] roundKey9,
   input  logic [127:0] roundKey10,
   output logic [127:0] cipherText,
   output logic         busy,
   output logic         done
);

   import aes_pkg::*;

   aesFsm_t      fsm, fsmNext;
   logic [3:0]   round;
   logic [127:0] aesState;
   logic [127:0] roundKey;
   logic [127:0] roundOut;
   logic         lastRound;
   logic         accept;
   logic         finish;

   assign lastRound = (round == 4'(NUM_ROUNDS));

   always_comb begin
      roundKey = roundKey0;
      case (round)
         4'd1:    roundKey = roundKey1;
         4'd2:    roundKey = roundKey2;
         4'd3:    roundKey = roundKey3;
         4'd4:    roundKey = roundKey4;
         4'd5:    roundKey = roundKey5;
         4'd6:    roundKey = roundKey6;
         4'd7:    roundKey = roundKey7;
         4'd8:    roundKey = roundKey8;
         4'd9:    roundKey = roundKey9;
         4'd10:   roundKey = roundKey10;
         default: roundKey = roundKey0;
      endcase
   end

   aes_round uRound (
      .state     (aesState),
      .roundKey  (roundKey),
      .lastRound (lastRound),
      .nextState (roundOut)
   );

   always_ff @(posedge clock) begin
      if (reset) fsm <= IDLE;
      else       fsm <= fsmNext;
   end

   // The done cycle is a gap: a held start is taken one edge later,
   // so blocks issue every 12 clocks and done is seen before restart.
   always_comb begin
      fsmNext = fsm;
      accept  = 1'b0;
      finish  = 1'b0;
      unique case (fsm)
         IDLE: begin
            if (startEncryption && keysReady && !done) begin
               accept  = 1'b1;
               fsmNext = RUN;
            end
         end
         RUN: begin
            if (lastRound) begin
               finish  = 1'b1;
               fsmNext = IDLE;
            end
         end
         default: fsmNext = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         round      <= 4'd0;
         aesState   <= '0;
         cipherText <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= finish;
         if (accept) begin
            aesState <= plainText ^ roundKey0;
            round    <= 4'd1;
            busy     <= 1'b1;
         end else if (fsm == RUN) begin
            aesState <= roundOut;
            if (finish) begin
               round      <= 4'd0;
               cipherText <= roundOut;
               busy       <= 1'b0;
            end else begin
               round <= round + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb_aes_encrypt_core: scoreboard bench with a byte-array AES model;
// round keys come from the bench's own key expansion.
module tb_aes_encrypt_core;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] R1_B   = 128'ha49c7ff2689f352b6b5bea43026a5049;

   typedef struct {
      logic [127:0] ct;
      int           cyc;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         startEncryption = 1'b0;
   logic         keysReady = 1'b0;
   logic [127:0] plainText = '0;
   logic [127:0] rk [11];
   logic [127:0] cipherText;
   logic         busy;
   logic         done;

   int           cyc = 0;
   int           checks = 0;
   int           passes = 0;
   logic [127:0] heldCt = '0;
   exp_t         expQ [$];
   logic [7:0]   sbT [256];

   aes_encrypt_core dut (
      .clock           (clock),
      .reset           (reset),
      .startEncryption (startEncryption),
      .keysReady       (keysReady),
      .plainText       (plainText),
      .roundKey0       (rk[0]),
      .roundKey1       (rk[1]),
      .roundKey2       (rk[2]),
      .roundKey3       (rk[3]),
      .roundKey4       (rk[4]),
      .roundKey5       (rk[5]),
      .roundKey6       (rk[6]),
      .roundKey7       (rk[7]),
      .roundKey8       (rk[8]),
      .roundKey9       (rk[9]),
      .roundKey10      (rk[10]),
      .cipherText      (cipherText),
      .busy            (busy),
      .done            (done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [129:0] act,
                        input logic [129:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %h, expected %h", nm, act, req);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      logic [7:0] r;
      r = (v << n) | (v >> (8 - n));
      return r;
   endfunction

   // S-box from its definition: GF(2^8) inverse then affine map.
   task automatic buildSbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbT[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                  ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic keyExpand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbT[t[23:16]], sbT[t[15:8]], sbT[t[7:0]], sbT[t[31:24]]}
                ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++)
         rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] aesEnc(input logic [127:0] pt,
                                           input int nRounds);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] blk;
      blk = pt ^ rk[0];
      for (int r = 1; r <= nRounds; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sbT[blk[127 - 8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
               t[4*c + w] = s[4*((c + w) % 4) + w];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
               if (r < 10)
                  s[4*c + w] = gmul(8'h02, t[4*c + w])
                             ^ gmul(8'h03, t[4*c + (w + 1) % 4])
                             ^ t[4*c + (w + 2) % 4] ^ t[4*c + (w + 3) % 4];
               else
                  s[4*c + w] = t[4*c + w];
         for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = s[i];
         blk = blk ^ rk[r];
      end
      return blk;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Called at a negedge with the core idle; returns after the accept edge.
   task automatic startBlock(input logic [127:0] pt, input logic [127:0] ct);
      exp_t e;
      e.ct  = ct;
      e.cyc = cyc + 11;
      expQ.push_back(e);
      plainText       = pt;
      startEncryption = 1'b1;
      @(negedge clock);
      startEncryption = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 60) begin
         @(negedge clock);
         n++;
      end
      check("drain", 130'(expQ.size()), 130'd0);
      @(negedge clock);
   endtask

   // Monitor: pops on done, otherwise holds cipherText to the last result.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (reset) begin
            expQ.delete();
            heldCt = '0;
            check("resetOutputs", {busy, done, cipherText}, 130'd0);
         end else if (done) begin
            if (expQ.size() == 0) begin
               check("unexpectedDone", 130'(expQ.size()), 130'd1);
            end else begin
               e = expQ.pop_front();
               check("cipherText", cipherText, e.ct);
               check("doneCycle", 130'(cyc), 130'(e.cyc));
               heldCt = e.ct;
            end
         end else begin
            check("cipherHold", cipherText, heldCt);
         end
      end
   end

   initial begin
      logic [127:0] pts [3];
      logic [127:0] k;
      logic [127:0] p;
      exp_t         e;
      int           a;
      foreach (rk[i]) rk[i] = '0;
      buildSbox();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      keyExpand(KEY_C1);
      keysReady = 1'b1;
      startBlock(PT_C1, CT_C1);
      check("busyRun", 130'(busy), 130'd1);
      waitDrain();

      keyExpand(KEY_B);
      startBlock(PT_B, CT_B);
      check("acceptState", dut.aesState, PT_B ^ rk[0]);
      @(negedge clock);
      check("round1State", dut.aesState, R1_B);
      check("round1Model", dut.aesState, aesEnc(PT_B, 1));
      waitDrain();

      keyExpand(KEY_C1);
      keysReady       = 1'b0;
      plainText       = PT_C1;
      startEncryption = 1'b1;
      repeat (20) begin
         @(negedge clock);
         check("busyNoKeys", 130'(busy), 130'd0);
      end
      keysReady = 1'b1;
      e.ct  = CT_C1;
      e.cyc = cyc + 11;
      expQ.push_back(e);
      @(negedge clock);
      startEncryption = 1'b0;
      waitDrain();

      startBlock(PT_C1, CT_C1);
      repeat (4) @(negedge clock);
      plainText       = rand128();
      startEncryption = 1'b1;
      @(negedge clock);
      startEncryption = 1'b0;
      waitDrain();

      startBlock(PT_B ^ 128'h1, aesEnc(PT_B ^ 128'h1, 10));
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("busyAfterReset", 130'(busy), 130'd0);
      repeat (15) @(negedge clock);
      startBlock(PT_C1, CT_C1);
      waitDrain();

      k = rand128();
      keyExpand(k);
      for (int i = 0; i < 3; i++) pts[i] = rand128();
      a = cyc + 1;
      for (int i = 0; i < 3; i++) begin
         e.ct  = aesEnc(pts[i], 10);
         e.cyc = a + 12*i + 10;
         expQ.push_back(e);
      end
      plainText       = pts[0];
      startEncryption = 1'b1;
      for (int i = 1; i < 3; i++) begin
         while (cyc < a + 12*(i - 1)) @(negedge clock);
         plainText = pts[i];
      end
      while (cyc < a + 24) @(negedge clock);
      startEncryption = 1'b0;
      waitDrain();

      for (int i = 0; i < 4; i++) begin
         k = rand128();
         p = rand128();
         keyExpand(k);
         startBlock(p, aesEnc(p, 10));
         waitDrain();
      end

      repeat (3) @(negedge clock);
      check("queueEmpty", 130'(expQ.size()), 130'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
